mem_clr_engine: RTL and testbench

MEM_CLR_ENGINE -- requirements
Module: mem_clr_engine

---
 rtl/mem_clr_engine.sv | 118 +++++++++++
 tb/tb_mem_clr_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_clr_engine.sv
// ---------------------------------------------------------------------------
// mem_clr_engine
//
// Fills one bank of a double-buffered frame buffer with a constant value.
// The bank that is cleared is the one not currently displayed (~swap). It is
// latched when a request is accepted in IDLE. Every pixel address of that
// bank is then written once, honouring write-port back-pressure.
//
// Ports
//   clk            in   rising-edge system clock
//   reset          in   asynchronous active-low reset
//   mem_str_clr    in   clear request level; dropping it aborts or acknowledges
//   swap           in   current bank-swap state from the system controller
//   mem_ready      in   write port accepts a write this cycle
//   mem_we         out  frame-buffer write enable (high for the whole CLEAR)
//   mem_addr       out  {bank, pixel_cnt} while clearing, zero otherwise
//   mem_data       out  constant CLR_VAL
//   mem_clr_finish out  high in DONE until the request is withdrawn
//   busy           out  high while in CLEAR
// ---------------------------------------------------------------------------
module mem_clr_engine #(
    parameter int unsigned H_RES   = 160,
    parameter int unsigned V_RES   = 120,
    parameter int unsigned CNT_W   = 15,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLR_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_str_clr,
    input  logic              swap,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [CNT_W:0]    mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_clr_finish,
    output logic              busy
);

    localparam int unsigned      PIXELS   = H_RES * V_RES;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bank_q, bank_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        case (state_q)
            StIdle: begin
                // Bank is latched here only, so swap changes mid-clear are ignored.
                if (mem_str_clr) begin
                    bank_d  = ~swap;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (!mem_str_clr) begin
                    // Abort takes priority over completing the last pixel.
                    state_d = StIdle;
                    cnt_d   = '0;
                    bank_d  = 1'b0;
                end else if (mem_ready) begin
                    // mem_we is always high here, so ready alone means accepted.
                    // The counter stops at the last pixel instead of wrapping.
                    if (cnt_q == LAST_PIX) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                if (!mem_str_clr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    bank_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                bank_d  = 1'b0;
            end
        endcase
    end

    // Outputs decode the registered state only, so reset clears them at once.
    always_comb begin
        busy           = (state_q == StClear);
        mem_we         = busy;
        mem_clr_finish = (state_q == StDone);
        mem_addr       = busy ? {bank_q, cnt_q} : '0;
        mem_data       = DATA_W'(CLR_VAL);
    end

endmodule

// File: tb/tb_mem_clr_engine.sv
module tb_mem_clr_engine;

    logic       clk;
    logic       reset;
    logic       mem_str_clr;
    logic       swap;
    logic       mem_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_clr_finish;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mem_clr_engine #(
        .H_RES  (4),
        .V_RES  (2),
        .CNT_W  (4),
        .DATA_W (8),
        .CLR_VAL(165)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_str_clr   (mem_str_clr),
        .swap          (swap),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_clr_finish(mem_clr_finish),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout: {mem_we, busy, mem_clr_finish, mem_addr[4:0]}

    task automatic test_reset();
        logic [7:0] exp;
        #2;
        exp = 8'h00;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL idle_no_request cyc=%0d got=%h exp=%h", i,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        swap = 1'b0; mem_ready = 1'b1; mem_str_clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'h10 + 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL basic_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        checks++;
        if (mem_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data got=%h exp=a5", mem_data);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = 8'h20;
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL basic_finish cyc=%0d got=%h exp=%h", i + 9,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
        exp = 8'h00;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL basic_release got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
    endtask

    task automatic test_stall();
        logic [4:0] tbl [0:9];
        logic [7:0] exp;
        int         acc;
        tbl = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h13, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
        acc = 0;
        swap = 1'b0; mem_ready = 1'b1; mem_str_clr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = {3'b110, tbl[i]};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL stall_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
            mem_ready = !(i == 3 || i == 4);
            if (mem_we && mem_ready) acc++;
        end
        @(negedge clk);
        exp = 8'h20;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL stall_finish cyc=11 got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        checks++;
        if (acc !== 8) begin
            errors++;
            $display("FAIL stall_accepted got=%0d exp=8", acc);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_swap();
        logic [7:0] exp;
        swap = 1'b1; mem_ready = 1'b1; mem_str_clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL swap_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
            if (i == 2 || i == 5) swap = ~swap;
        end
        @(negedge clk);
        exp = 8'h20;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL swap_finish got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] exp;
        swap = 1'b0; mem_ready = 1'b1; mem_str_clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'h10 + 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL abort_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        mem_str_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = 8'h00;
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%h exp=%h", i,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        mem_str_clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'h10 + 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL abort_restart cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        @(negedge clk);
        exp = 8'h20;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL abort_restart_finish got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [7:0] exp;
        swap = 1'b0; mem_ready = 1'b1; mem_str_clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'h10 + 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL rst_pre_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        #2 reset = 1'b0;
        #1;
        exp = 8'h00;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL rst_async got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        swap = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL rst_held got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = {3'b110, 5'(i)};
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL rst_fresh_write cyc=%0d got=%h exp=%h", i + 1,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
        end
        @(negedge clk);
        exp = 8'h20;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL rst_fresh_finish got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_done_rerequest();
        logic [7:0] exp;
        swap = 1'b0; mem_ready = 1'b1; mem_str_clr = 1'b1;
        repeat (9) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp = 8'h20;
            checks++;
            if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
                errors++;
                $display("FAIL done_hold cyc=%0d got=%h exp=%h", i,
                         {mem_we, busy, mem_clr_finish, mem_addr}, exp);
            end
            @(negedge clk);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
        exp = 8'h00;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL done_release got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        mem_str_clr = 1'b1;
        @(negedge clk);
        exp = 8'hD0;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL done_rerequest got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
        mem_str_clr = 1'b0;
        @(negedge clk);
        exp = 8'h00;
        checks++;
        if ({mem_we, busy, mem_clr_finish, mem_addr} !== exp) begin
            errors++;
            $display("FAIL done_final_abort got=%h exp=%h", {mem_we, busy, mem_clr_finish, mem_addr}, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        mem_str_clr = 1'b0;
        swap        = 1'b0;
        mem_ready   = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_swap();
        test_abort();
        test_async_reset();
        test_done_rerequest();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
